// File: rtl/spam_master_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// Module   : spam_master_arbiter_pkg
// Purpose  : SPAM bus field widths, device IDs and arbiter state encodings.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package spam_master_arbiter_pkg;

  localparam int SPAM_DID_HI  = 3;
  localparam int SPAM_ADDR_HI = 23;
  localparam int SPAM_DATA_HI = 31;

  localparam logic [SPAM_DID_HI:0] SPAM_DID_CONSOLE = 4'h1;
  localparam logic [SPAM_DID_HI:0] SPAM_DID_TIMER   = 4'h2;
  localparam logic [SPAM_DID_HI:0] SPAM_DID_GPIO    = 4'h3;
  localparam logic [SPAM_DID_HI:0] SPAM_DID_SPI     = 4'h4;

  localparam logic [1:0] SPAM_ARB_IDLE = 2'd0;
  localparam logic [1:0] SPAM_ARB_WAIT = 2'd1;
  localparam logic [1:0] SPAM_ARB_ACK  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/spam_rr_pick.sv
// ----------------------------------------------------------------------------
// Module   : spam_rr_pick
// Purpose  : Combinational round-robin picker; first request after 'last'.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module spam_rr_pick #(
  parameter int NREQ = 4,
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic            any,
  output logic [IDXW-1:0] grant
);

  // Scan farthest-first so the nearest requester after 'last' overwrites.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        any   = 1'b1;
        grant = IDXW'((int'(last) + k) % NREQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spam_master_arbiter.sv
// ----------------------------------------------------------------------------
// Module   : spam_master_arbiter
// Purpose  : Round-robin sharing of the single SPAM master port, with timeout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module spam_master_arbiter
  import spam_master_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0]               req_r_nw,
  input  logic [NREQ*(SPAM_DID_HI+1)-1:0]  req_did,
  input  logic [NREQ*(SPAM_ADDR_HI+1)-1:0] req_addr,
  input  logic [NREQ*(SPAM_DATA_HI+1)-1:0] req_wdata,
  output logic [NREQ-1:0]               req_ack,
  output logic                          req_err,
  output logic [SPAM_DATA_HI:0]         req_rdata,
  output logic                          spamo_valid,
  output logic                          spamo_r_nw,
  output logic [SPAM_DID_HI:0]          spamo_did,
  output logic [SPAM_ADDR_HI:0]         spamo_addr,
  output logic [SPAM_DATA_HI:0]         spamo_data,
  input  logic                          spami_busy_b,
  input  logic [SPAM_DATA_HI:0]         spami_data
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = $clog2(TIMEOUT);
  localparam int DIDW = SPAM_DID_HI + 1;
  localparam int AW   = SPAM_ADDR_HI + 1;
  localparam int DW   = SPAM_DATA_HI + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] rr_last_q, rr_last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] req_ack_q, req_ack_d;
  logic            req_err_q, req_err_d;
  logic [DW-1:0]   req_rdata_q, req_rdata_d;
  logic            spamo_valid_q, spamo_valid_d;
  logic            spamo_r_nw_q, spamo_r_nw_d;
  logic [DIDW-1:0] spamo_did_q, spamo_did_d;
  logic [AW-1:0]   spamo_addr_q, spamo_addr_d;
  logic [DW-1:0]   spamo_data_q, spamo_data_d;

  logic            w_any;
  logic [IDXW-1:0] w_pick;
  logic [NREQ-1:0] w_ack_onehot;

  spam_rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .last  (rr_last_q),
    .any   (w_any),
    .grant (w_pick)
  );

  assign w_ack_onehot = NREQ'(1) << grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SPAM_ARB_IDLE;
      grant_q       <= '0;
      rr_last_q     <= IDXW'(NREQ - 1);
      cnt_q         <= '0;
      req_ack_q     <= '0;
      req_err_q     <= 1'b0;
      req_rdata_q   <= '0;
      spamo_valid_q <= 1'b0;
      spamo_r_nw_q  <= 1'b0;
      spamo_did_q   <= '0;
      spamo_addr_q  <= '0;
      spamo_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_last_q     <= rr_last_d;
      cnt_q         <= cnt_d;
      req_ack_q     <= req_ack_d;
      req_err_q     <= req_err_d;
      req_rdata_q   <= req_rdata_d;
      spamo_valid_q <= spamo_valid_d;
      spamo_r_nw_q  <= spamo_r_nw_d;
      spamo_did_q   <= spamo_did_d;
      spamo_addr_q  <= spamo_addr_d;
      spamo_data_q  <= spamo_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SPAM_ARB_IDLE: if (w_any) state_d = SPAM_ARB_WAIT;
      SPAM_ARB_WAIT: if (spami_busy_b || cnt_q == CNT_LAST) state_d = SPAM_ARB_ACK;
      SPAM_ARB_ACK:  state_d = SPAM_ARB_IDLE;
      default:       state_d = SPAM_ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_d       = grant_q;
    rr_last_d     = rr_last_q;
    cnt_d         = cnt_q;
    req_ack_d     = '0;
    req_err_d     = req_err_q;
    req_rdata_d   = req_rdata_q;
    spamo_valid_d = 1'b0;
    spamo_r_nw_d  = spamo_r_nw_q;
    spamo_did_d   = spamo_did_q;
    spamo_addr_d  = spamo_addr_q;
    spamo_data_d  = spamo_data_q;
    case (state_q)
      SPAM_ARB_IDLE: begin
        if (w_any) begin
          spamo_valid_d = 1'b1;
          spamo_r_nw_d  = req_r_nw[w_pick];
          spamo_did_d   = req_did[int'(w_pick)*DIDW +: DIDW];
          spamo_addr_d  = req_addr[int'(w_pick)*AW +: AW];
          spamo_data_d  = req_wdata[int'(w_pick)*DW +: DW];
          grant_d       = w_pick;
          rr_last_d     = w_pick;
          cnt_d         = '0;
        end
      end
      SPAM_ARB_WAIT: begin
        // A response in the expiring cycle still counts as a good completion.
        if (spami_busy_b) begin
          req_rdata_d = spami_data;
          req_err_d   = 1'b0;
          req_ack_d   = w_ack_onehot;
        end else if (cnt_q == CNT_LAST) begin
          req_rdata_d = '1;
          req_err_d   = 1'b1;
          req_ack_d   = w_ack_onehot;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SPAM_ARB_ACK: req_err_d = 1'b0;
      default: ;
    endcase
  end

  assign req_ack     = req_ack_q;
  assign req_err     = req_err_q;
  assign req_rdata   = req_rdata_q;
  assign spamo_valid = spamo_valid_q;
  assign spamo_r_nw  = spamo_r_nw_q;
  assign spamo_did   = spamo_did_q;
  assign spamo_addr  = spamo_addr_q;
  assign spamo_data  = spamo_data_q;

endmodule

`default_nettype wire

// File: tb/tb_spam_master_arbiter.sv
// ----------------------------------------------------------------------------
// Module   : tb_spam_master_arbiter
// Purpose  : Directed self-checking bench for spam_master_arbiter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spam_master_arbiter;
  import spam_master_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int IW      = SPAM_DID_HI + 1;
  localparam int AW      = SPAM_ADDR_HI + 1;
  localparam int DW      = SPAM_DATA_HI + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_r_nw;
  logic [NREQ*IW-1:0]   req_did;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ack;
  logic                 req_err;
  logic [DW-1:0]        req_rdata;
  logic                 spamo_valid;
  logic                 spamo_r_nw;
  logic [IW-1:0]        spamo_did;
  logic [AW-1:0]        spamo_addr;
  logic [DW-1:0]        spamo_data;
  logic                 spami_busy_b;
  logic [DW-1:0]        spami_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spam_master_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_r_nw     (req_r_nw),
    .req_did      (req_did),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .req_rdata    (req_rdata),
    .spamo_valid  (spamo_valid),
    .spamo_r_nw   (spamo_r_nw),
    .spamo_did    (spamo_did),
    .spamo_addr   (spamo_addr),
    .spamo_data   (spamo_data),
    .spami_busy_b (spami_busy_b),
    .spami_data   (spami_data)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [IW-1:0] did,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    req_r_nw[i]           = rnw;
    req_did[i*IW +: IW]   = did;
    req_addr[i*AW +: AW]  = addr;
    req_wdata[i*DW +: DW] = wd;
    req_valid[i]          = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " ack"},   32'(req_ack), 32'h0);
    check_val({tag, " err"},   32'(req_err), 32'h0);
    check_val({tag, " rdata"}, req_rdata, 32'h0);
    check_val({tag, " valid"}, 32'(spamo_valid), 32'h0);
    check_val({tag, " fields"}, 32'({spamo_r_nw, spamo_did, spamo_addr}), 32'h0);
    check_val({tag, " sdata"}, spamo_data, 32'h0);
  endtask

  // Called from an IDLE cycle with the expected requester's request in place.
  // 'delay' is the WAIT cycle (0 = valid cycle) in which the responder strobes; -1 = silent.
  task automatic run_txn(input string tag, input int who, input logic rnw,
                         input logic [IW-1:0] did, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int delay, input logic [DW-1:0] resp,
                         input logic exp_err, input logic [DW-1:0] exp_rd, input bit drop);
    int n;
    int w;
    int exp_lat;
    logic [NREQ-1:0] exp_ack;
    n = 0;
    do begin
      step();
      n++;
    end while (!spamo_valid && n < 8);
    check_val({tag, " grant lat"}, 32'(n), 32'd1);
    check_val({tag, " r_nw"}, 32'(spamo_r_nw), 32'(rnw));
    check_val({tag, " did"},  32'(spamo_did), 32'(did));
    check_val({tag, " addr"}, 32'(spamo_addr), 32'(addr));
    check_val({tag, " data"}, spamo_data, wd);
    w = 0;
    do begin
      spami_busy_b = (w == delay);
      spami_data   = (w == delay) ? resp : 32'hDEAD_BEEF;
      step();
      spami_busy_b = 1'b0;
      w++;
      if (w == 1) check_val({tag, " valid 1cyc"}, 32'(spamo_valid), 32'h0);
    end while (req_ack == '0 && w < 40);
    exp_lat = (delay >= 0 && delay < TIMEOUT) ? delay + 1 : TIMEOUT;
    exp_ack = NREQ'(1) << who;
    check_val({tag, " ack lat"}, 32'(w), 32'(exp_lat));
    check_val({tag, " ack"},     32'(req_ack), 32'(exp_ack));
    check_val({tag, " err"},     32'(req_err), 32'(exp_err));
    check_val({tag, " rdata"},   req_rdata, exp_rd);
    if (drop) req_valid[who] = 1'b0;
    step();
    check_val({tag, " ack clr"}, 32'(req_ack), 32'h0);
    check_val({tag, " err clr"}, 32'(req_err), 32'h0);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    req_valid    = '0;
    req_r_nw     = '0;
    req_did      = '0;
    req_addr     = '0;
    req_wdata    = '0;
    spami_busy_b = 1'b0;
    spami_data   = '0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Requester 1 writes 'A' to the console; rdata is captured even on writes.
    set_req(1, 1'b0, SPAM_DID_CONSOLE, 24'h0, 32'h41);
    run_txn("wr1", 1, 1'b0, SPAM_DID_CONSOLE, 24'h0, 32'h41, 1, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 1'b1);

    set_req(2, 1'b1, SPAM_DID_CONSOLE, 24'h4, 32'h0);
    run_txn("rd2", 2, 1'b1, SPAM_DID_CONSOLE, 24'h4, 32'h0, 1, 32'h0000_0141, 1'b0, 32'h0000_0141, 1'b1);

    // Fairness from a fresh reset: all four hold reads.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, SPAM_DID_CONSOLE, 24'h100 + 24'(i), 32'h0);
    for (int k = 0; k < 8; k++)
      run_txn($sformatf("rr%0d", k), k % NREQ, 1'b1, SPAM_DID_CONSOLE, 24'h100 + 24'(k % NREQ),
              32'h0, 1, 32'h200 + 32'(k), 1'b0, 32'h200 + 32'(k), 1'b0);
    req_valid = '0;
    step();

    // Unmapped device, responder silent: timeout error ack.
    set_req(2, 1'b1, 4'hF, 24'h123, 32'h0);
    run_txn("tmo", 2, 1'b1, 4'hF, 24'h123, 32'h0, -1, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    set_req(3, 1'b0, SPAM_DID_GPIO, 24'h8, 32'hCAFE_0003);
    run_txn("post", 3, 1'b0, SPAM_DID_GPIO, 24'h8, 32'hCAFE_0003, 1, 32'h0000_0777, 1'b0, 32'h0000_0777, 1'b1);

    // Response on the last timeout cycle beats the timeout.
    set_req(0, 1'b1, 4'hF, 24'h55, 32'h0);
    run_txn("edge", 0, 1'b1, 4'hF, 24'h55, 32'h0, TIMEOUT - 1, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1);

    // Reset in the middle of a read to requester 1.
    set_req(1, 1'b1, SPAM_DID_TIMER, 24'h30, 32'h0);
    n = 0;
    do begin
      step();
      n++;
    end while (!spamo_valid && n < 8);
    check_val("mid grant", 32'(spamo_valid), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '0;
    check_all_zero("midrst");
    spami_busy_b = 1'b1;
    spami_data   = 32'h9999_9999;
    step();
    spami_busy_b = 1'b0;
    check_val("late busy ack", 32'(req_ack), 32'h0);
    step();
    check_val("late busy ack2", 32'(req_ack), 32'h0);
    check_val("late busy valid", 32'(spamo_valid), 32'h0);
    check_val("late busy rdata", req_rdata, 32'h0);

    set_req(3, 1'b1, SPAM_DID_SPI, 24'h333, 32'h0);
    set_req(0, 1'b1, SPAM_DID_SPI, 24'h000, 32'h0);
    run_txn("postrst", 0, 1'b1, SPAM_DID_SPI, 24'h000, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b1);
    req_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spam_master_arbiter.md
Name: spam_master_arbiter

Overview:
- Shares the single SPAM master port (spamo_*/spami_*) among NREQ requesters, e.g. CPU core, debug/boot loader, DMA.
- Arbitrates round-robin and issues one single-cycle spamo_valid transaction at a time.
- Waits for the peripheral's spami_busy_b response strobe, then returns read data and a one-cycle ack to the granted requester.
- A timeout converts a missing response (unmapped DID) into an error ack, so the bus never hangs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 16, cycles waited in WAIT for spami_busy_b before an error ack (≥2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request; held with all fields stable until that requester's req_ack.
- req_r_nw  in  NREQ  1 = read, 0 = write.
- req_did  in  NREQ*(SPAM_DID_HI+1)  device ID, requester i at slice i.
- req_addr  in  NREQ*(SPAM_ADDR_HI+1)  address.
- req_wdata  in  NREQ*(SPAM_DATA_HI+1)  write data.
- req_ack  out  NREQ  one-cycle completion pulse, at most one bit set.
- req_err  out  1  valid with req_ack; 1 = timed out.
- req_rdata  out  SPAM_DATA_HI+1  valid with req_ack; shared by all requesters.
- spamo_valid  out  1  transaction strobe, exactly one cycle per transaction.
- spamo_r_nw, spamo_did, spamo_addr, spamo_data  out  1 / SPAM_DID_HI+1 / SPAM_ADDR_HI+1 / SPAM_DATA_HI+1  transaction fields; registered, valid with spamo_valid.
- spami_busy_b  in  1  peripheral response strobe; high for one cycle = transaction complete.
- spami_data  in  SPAM_DATA_HI+1  response data, valid with spami_busy_b.

Behaviour:
- Reset state: state=IDLE, rr_last=NREQ-1 (requester 0 wins first), timeout counter 0.
- All outputs are registered and 0 under reset, including spamo_* fields, req_ack, req_err and req_rdata.
- IDLE:
  - If any req_valid, pick the first set bit scanning from rr_last+1 upward with wrap.
  - Latch that requester's r_nw/did/addr/wdata into spamo_*, set spamo_valid<=1, record grant and rr_last<=grant, clear the counter, go to WAIT.
  - If no req_valid, stay in IDLE with spamo_valid=0.
- WAIT:
  - spamo_valid<=0; spamo fields are held.
  - On spami_busy_b=1: req_rdata<=spami_data (also captured on writes), req_err<=0, req_ack[grant]<=1, go to ACK.
  - Else if counter==TIMEOUT-1: req_rdata<=all ones, req_err<=1, req_ack[grant]<=1, go to ACK.
  - Else counter+1.
  - If the response arrives in the same cycle the count expires, the response wins (err=0).
- ACK:
  - req_ack/req_err/req_rdata are high/valid for this one cycle only; next edge clears req_ack and req_err and goes to IDLE.
  - The requester samples req_ack at the edge ending ACK. Its req_valid in the following IDLE cycle reflects any new request, so there is no double grant.
- Latency (responder answering one cycle after valid, as the console does):
  - request sampled at edge N;
  - spamo_valid high in cycle N+1;
  - spami_busy_b in cycle N+2;
  - req_ack in cycle N+3;
  - next grant sampled at edge N+4.
  - Back-to-back throughput: one transaction per 4 cycles.
- spami_busy_b or spami_data seen outside WAIT is ignored (no ack, no state change).
- A requester dropping req_valid before its ack is a protocol violation. The in-flight transaction still completes and still acks.
- rst mid-transaction: abort to IDLE, all outputs 0, no ack issued; rr_last is reset.
- Fairness: with all requesters continuously requesting, grants follow 0,1,…,NREQ-1,0,…

Decomposition:
- spam_defines.vh holds SPAM_DID_HI=3, SPAM_ADDR_HI=23, SPAM_DATA_HI=31 and the SPAM_DID_* device IDs.
- Add SPAM_ARB_IDLE/WAIT/ACK state encodings (2 bits) to spam_defines.vh.
- One combinational sub-module, spam_rr_pick (params NREQ; in: req[NREQ], last[idx]; out: any, grant[idx]). Instantiated once; reusable by other SPAM arbiters.

Test Plan:
- Reset, then requester 1 writes did=SPAM_DID_CONSOLE, addr=0, data=0x41 (responder answers in 1 cycle):
  - spamo_valid high exactly 1 cycle with r_nw=0 and data 0x00000041;
  - req_ack=4'b0010 three cycles after the request edge, err=0.
- Requester 2 reads the console while the responder returns spami_data=0x00000141:
  - req_rdata=0x00000141 with req_ack=4'b0100, err=0.
- All four requesters hold reads continuously for 8 transactions:
  - grant order 0,1,2,3,0,1,2,3;
  - each spamo_valid is a single cycle;
  - never two ack bits at once.
- Read of unmapped did=0xF with the responder silent:
  - ack on cycle TIMEOUT of WAIT with err=1 and rdata=0xFFFFFFFF;
  - a following valid request is granted normally.
- Responder strobes spami_busy_b exactly on the final timeout cycle with data 0x12345678:
  - ack with err=0 and rdata=0x12345678.
- Assert rst one cycle after spamo_valid during a read:
  - no req_ack; all outputs 0 next cycle;
  - a spami_busy_b arriving after reset is ignored;
  - the first post-reset grant goes to requester 0 when requesters 0 and 3 both request.
